// File: rtl/alu_cmd_driver_if.sv
// Command, result and ALU-side signals of the ALU command driver.
// slave is the driver's view; master is the command source, result consumer and ALU.
interface alu_cmd_driver_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ch;
  logic [WIDTH-1:0] alu_f;
  logic             zero_f;
  logic             over_f;
  logic             cout_f;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_f;
  logic             res_zero;
  logic             res_over;
  logic             res_cout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_ch,
    input  alu_f, zero_f, over_f, cout_f,
    output res_valid, res_f, res_zero, res_over, res_cout,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_ch,
    output alu_f, zero_f, over_f, cout_f,
    input  res_valid, res_f, res_zero, res_over, res_cout,
    output res_ready
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Drives a combinational ALU from registered operands, captures its outputs after SETTLE cycles.
// Latency: accept at edge k, result valid after edge k+SETTLE; command side stalls until the result handshake.
module alu_cmd_driver #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_driver_if.slave  bus,
  output logic [CNT_W-1:0] op_count
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;

  // cmd_ready/res_valid are registered alongside state so they stay a pure function of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      bus.cmd_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_ch    <= '0;
      bus.res_f     <= '0;
      bus.res_zero  <= 1'b0;
      bus.res_over  <= 1'b0;
      bus.res_cout  <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.alu_a     <= bus.cmd_a;
            bus.alu_b     <= bus.cmd_b;
            bus.alu_ch    <= bus.cmd_op;
            settle_cnt    <= SW'(SETTLE - 1);
            bus.cmd_ready <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
          end else begin
            bus.res_f     <= bus.alu_f;
            bus.res_zero  <= bus.zero_f;
            bus.res_over  <= bus.over_f;
            bus.res_cout  <= bus.cout_f;
            bus.res_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            op_count      <= op_count + CNT_W'(1);
            bus.res_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.res_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench: dut_a (SETTLE=1, CNT_W=2) runs the op sequence and counter wrap; dut_b (SETTLE=3) covers mid-op reset.
module tb_alu_cmd_driver;
  typedef struct packed {
    logic [3:0] f;
    logic       zero;
    logic       over;
    logic       cout;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  logic [1:0] exp_cnt = '0;
  int         n_err = 0;
  int         n_chk = 0;
  res_t       exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_driver_if #(.WIDTH(4)) bus_a ();
  alu_cmd_driver_if #(.WIDTH(4)) bus_b ();

  alu_cmd_driver #(.WIDTH(4), .SETTLE(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .op_count(cnt_a)
  );
  alu_cmd_driver #(.WIDTH(4), .SETTLE(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .op_count(cnt_b)
  );

  function automatic res_t alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    res_t       r;
    logic [4:0] s;
    r = '0;
    s = '0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r.f = s[3:0]; r.cout = s[4];
        r.over = (a[3] == b[3]) && (r.f[3] != a[3]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r.f = s[3:0]; r.cout = s[4];
        r.over = (a[3] != b[3]) && (r.f[3] != a[3]);
      end
      3'b010: r.f = ~a;
      3'b011: r.f = a & b;
      3'b100: r.f = a | b;
      3'b101: r.f = a ^ b;
      3'b110: r.f = {3'b000, a < b};
      default: r.f = {3'b000, a == b};
    endcase
    r.zero = (r.f == 4'd0);
    return r;
  endfunction

  res_t ra, rb, got_a, got_b;
  always_comb ra = alu_model(bus_a.alu_ch, bus_a.alu_a, bus_a.alu_b);
  always_comb rb = alu_model(bus_b.alu_ch, bus_b.alu_a, bus_b.alu_b);
  assign bus_a.alu_f = ra.f;
  assign bus_a.zero_f = ra.zero;
  assign bus_a.over_f = ra.over;
  assign bus_a.cout_f = ra.cout;
  assign bus_b.alu_f = rb.f;
  assign bus_b.zero_f = rb.zero;
  assign bus_b.over_f = rb.over;
  assign bus_b.cout_f = rb.cout;
  assign got_a = {bus_a.res_f, bus_a.res_zero, bus_a.res_over, bus_a.res_cout};
  assign got_b = {bus_b.res_f, bus_b.res_zero, bus_b.res_over, bus_b.res_cout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called and returns at a negedge; optionally leaves a second command pending on cmd_valid.
  task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int hold,
                       input logic nxt, input logic [2:0] n_op, input logic [3:0] n_a, input logic [3:0] n_b);
    int   cyc;
    res_t held;
    res_t exp;
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_op = op;
    bus_a.cmd_a = a;
    bus_a.cmd_b = b;
    chk("idle_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    exp_q.push_back(alu_model(op, a, b));
    @(negedge clk);
    if (nxt) begin
      bus_a.cmd_op = n_op;
      bus_a.cmd_a = n_a;
      bus_a.cmd_b = n_b;
    end else begin
      bus_a.cmd_valid = 1'b0;
    end
    chk("alu_a", 32'(bus_a.alu_a), 32'(a));
    chk("alu_b", 32'(bus_a.alu_b), 32'(b));
    chk("alu_ch", 32'(bus_a.alu_ch), 32'(op));
    chk("wait_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
    cyc = 0;
    while (!bus_a.res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd1);
    held = got_a;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_res", 32'(got_a), 32'(held));
      chk("hold_res_valid", 32'(bus_a.res_valid), 32'd1);
      chk("hold_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
      chk("hold_alu_a", 32'(bus_a.alu_a), 32'(a));
    end
    bus_a.res_ready = 1'b1;
    chk("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("result", 32'(got_a), 32'(exp));
    end
    @(negedge clk);
    bus_a.res_ready = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    chk("op_count", 32'(cnt_a), 32'(exp_cnt));
    chk("post_res_valid", 32'(bus_a.res_valid), 32'd0);
    chk("post_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    chk("post_alu_a", 32'(bus_a.alu_a), 32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    logic seen;
    res_t exp;
    rst = 1'b0;
    rst_b = 1'b0;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_op = '0; bus_a.cmd_a = '0; bus_a.cmd_b = '0; bus_a.res_ready = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_op = '0; bus_b.cmd_a = '0; bus_b.cmd_b = '0; bus_b.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rst_b = 1'b1;
    chk("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus_a.res_valid), 32'd0);
    chk("rst_alu", 32'({bus_a.alu_a, bus_a.alu_b, bus_a.alu_ch}), 32'd0);
    chk("rst_res", 32'(got_a), 32'd0);
    chk("rst_op_count", 32'(cnt_a), 32'd0);
    chk("rst_b_cmd_ready", 32'(bus_b.cmd_ready), 32'd1);
    chk("rst_b_op_count", 32'(cnt_b), 32'd0);

    do_op(3'b000, 4'b0111, 4'b0001, 0, 1'b0, 3'b0, 4'b0, 4'b0);
    chk("add_f", 32'(bus_a.res_f), 32'b1000);
    chk("add_flags", 32'({bus_a.res_zero, bus_a.res_over, bus_a.res_cout}), 32'b010);
    do_op(3'b001, 4'b0101, 4'b0101, 0, 1'b0, 3'b0, 4'b0, 4'b0);
    chk("sub_f", 32'(bus_a.res_f), 32'd0);
    chk("sub_flags", 32'({bus_a.res_zero, bus_a.res_over, bus_a.res_cout}), 32'b101);
    do_op(3'b101, 4'b1100, 4'b1010, 5, 1'b1, 3'b110, 4'b0011, 4'b0100);
    chk("xor_f", 32'(bus_a.res_f), 32'b0110);
    do_op(3'b110, 4'b0011, 4'b0100, 0, 1'b0, 3'b0, 4'b0, 4'b0);
    chk("lt_f", 32'(bus_a.res_f), 32'b0001);
    do_op(3'b010, 4'b0000, 4'b1001, 2, 1'b0, 3'b0, 4'b0, 4'b0);
    chk("not_f", 32'(bus_a.res_f), 32'b1111);
    chk("wrap_count", 32'(cnt_a), 32'd1);

    // Abort in the second WAIT cycle of a SETTLE=3 op.
    bus_b.cmd_valid = 1'b1; bus_b.cmd_op = 3'b000; bus_b.cmd_a = 4'd1; bus_b.cmd_b = 4'd1;
    @(negedge clk);
    bus_b.cmd_valid = 1'b0;
    chk("b_accept", 32'(bus_b.cmd_ready), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("b_abort_ready", 32'(bus_b.cmd_ready), 32'd1);
    chk("b_abort_alu_a", 32'(bus_b.alu_a), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_b.res_valid) seen = 1'b1;
    end
    chk("b_no_result", 32'(seen), 32'd0);
    chk("b_abort_count", 32'(cnt_b), 32'd0);

    bus_b.cmd_valid = 1'b1; bus_b.cmd_op = 3'b011; bus_b.cmd_a = 4'b1110; bus_b.cmd_b = 4'b0111;
    exp_q.push_back(alu_model(3'b011, 4'b1110, 4'b0111));
    @(negedge clk);
    bus_b.cmd_valid = 1'b0;
    cyc = 0;
    while (!bus_b.res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_latency", 32'(cyc), 32'd3);
    bus_b.res_ready = 1'b1;
    chk("b_sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("b_result", 32'(got_b), 32'(exp));
    end
    @(negedge clk);
    bus_b.res_ready = 1'b0;
    chk("b_op_count", 32'(cnt_b), 32'd1);
    chk("b_post_cmd_ready", 32'(bus_b.cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Sequential initiator for the team's 4-bit combinational ALU (a, b, alu_ch in; alu_f, zero_f, over_f, cout_f out).
- Accepts operation commands over a valid/ready handshake and drives the ALU operand and select inputs from registers.
- Waits a programmable settle time, then captures the result and flags into registers and returns them over a second valid/ready handshake.
- Sits between a command source (keyboard/switch front-end or test sequencer) and the ALU.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- SETTLE, 1, cycles (>=1) between driving the ALU and capturing its outputs.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset: the block resets on a rising clk edge while rst=0.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  ALU select: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 less-than, 111 equal.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- alu_a  out  WIDTH  registered operand to ALU a.
- alu_b  out  WIDTH  registered operand to ALU b.
- alu_ch  out  3  registered select to ALU alu_ch.
- alu_f  in  WIDTH  ALU result.
- zero_f, over_f, cout_f  in  1 each  ALU flags.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_f  out  WIDTH  captured result.
- res_zero, res_over, res_cout  out  1 each  captured flags.
- op_count  out  CNT_W  number of completed result handshakes.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE. alu_a, alu_b, alu_ch, res_f, res_zero, res_over, res_cout, op_count and the settle counter all reset to 0. res_valid=0. cmd_ready=1 from the first cycle after reset.
- Reset has priority over every other event and aborts any in-flight operation. No result is produced for an aborted command, and op_count is not incremented.
- States:
  - IDLE: cmd_ready=1, res_valid=0.
  - WAIT: cmd_ready=0, res_valid=0.
  - RESP: cmd_ready=0, res_valid=1.
- cmd_ready is a pure decode of state (Moore). It never depends combinationally on cmd_valid.
- IDLE to WAIT: on an edge with cmd_valid=1 (implies cmd_ready=1).
  - At that edge, alu_a<=cmd_a, alu_b<=cmd_b, alu_ch<=cmd_op, and the settle counter loads SETTLE-1.
- WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, at that edge capture res_f<=alu_f, res_zero<=zero_f, res_over<=over_f, res_cout<=cout_f, then go to RESP.
  - Result: the command is accepted at edge k, captured at edge k+SETTLE, and res_valid is high after edge k+SETTLE.
- RESP to IDLE: on an edge with res_ready=1. At that edge op_count<=op_count+1, wrapping modulo 2^CNT_W (all-ones + 1 = 0).
- In RESP, res_f and the res flags hold stable until the handshake completes, however long res_ready stays low.
- alu_a, alu_b and alu_ch change only at command acceptance and hold their last values in every state, including IDLE.
- cmd_valid=1 while not in IDLE is ignored; the source must hold its command until it sees cmd_ready.
- RESP does not bypass IDLE: a new command is accepted no earlier than the edge after the result handshake. Maximum throughput is one op per SETTLE+2 cycles.
- No arithmetic is done in this block. Result and flag values are exactly the ALU outputs sampled at the capture edge.

Test Plan:
- Reset: hold rst=0 for 2 edges, then release -> all outputs 0, cmd_ready=1, res_valid=0, op_count=0.
- Add overflow, SETTLE=1, bench ALU model: cmd_op=000, a=0111, b=0001 -> alu_a/alu_b/alu_ch=0111/0001/000 after the accept edge. One edge later: res_valid=1, res_f=1000, res_over=1, res_zero=0, res_cout=0. res_ready=1 -> op_count=1.
- Sub to zero: cmd_op=001, a=b=0101 -> res_f=0000, res_zero=1, res_over=0, res_cout=1.
- Back-pressure: xor a=1100 b=1010 with res_ready=0 for 5 cycles, and a second cmd_valid asserted during that time -> res_f=0110 held stable, cmd_ready stays 0, second command not accepted until the cycle after the res handshake.
- Reset mid-op, SETTLE=3: rst=0 in the second WAIT cycle -> IDLE, res_valid never asserts, op_count unchanged.
- Counter wrap, CNT_W=2: 5 completed ops -> op_count sequence 1,2,3,0,1.
